// File: rtl/mem_param_clr.sv
// Single-port word memory with per-bit write mask, selectable read-first /
// write-first read-back on writes, and a sweep engine that writes CLR_VAL
// to every word after reset or on request. Accepted accesses have one cycle
// of latency. Accesses are refused while the sweep runs, and out-of-range
// addresses are refused and flagged on oor.
module mem_param_clr #(
   parameter int               WIDTH   = 8,
   parameter int               DEPTH   = 1024,
   parameter int               RD_MODE = 0,
   parameter logic [WIDTH-1:0] CLR_VAL = '0,
   localparam int              AW      = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             wr,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] d_i,
   input  logic [WIDTH-1:0] wmask,
   input  logic             clr_req,
   output logic [WIDTH-1:0] d_o,
   output logic             rd_vld,
   output logic             busy,
   output logic             oor
);

   localparam logic [0:0]    ST_IDLE  = 1'b0;
   localparam logic [0:0]    ST_CLEAR = 1'b1;
   // DEPTH is held one bit wider than the address so that a power-of-two
   // DEPTH still compares correctly against every address value.
   localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST     = AW'(DEPTH - 1);

   logic [0:0]       r_state;
   logic [AW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_d_o;
   logic             r_rd_vld;
   logic             r_oor;

   logic             w_busy;
   logic             w_in_range;
   logic             w_accept;
   logic             w_oor_hit;
   logic [WIDTH-1:0] w_old;
   logic [WIDTH-1:0] w_merged;

   assign w_busy     = (r_state == ST_CLEAR);
   assign w_in_range = ({1'b0, addr} < DEPTH_W);
   // rst is excluded from these in the always blocks, where it takes priority.
   assign w_accept   = en & ~w_busy & w_in_range;
   assign w_oor_hit  = en & ~w_busy & ~w_in_range;
   assign w_old      = r_mem[addr];
   assign w_merged   = (w_old & ~wmask) | (d_i & wmask);

   // Clear engine: reset or a request starts a sweep from address 0, and the
   // edge that writes the last word returns the engine to idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_CLEAR;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (clr_req) begin
                  r_state <= ST_CLEAR;
                  r_cnt   <= '0;
               end
            end
            default: begin
               if (r_cnt == LAST) begin
                  r_state <= ST_IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   // Array write port: a sweep write or a masked user write, never both,
   // because user accesses are refused while the sweep runs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (w_busy) begin
            r_mem[r_cnt] <= CLR_VAL;
         end else if (w_accept && wr) begin
            r_mem[addr] <= w_merged;
         end
      end
   end

   // Registered read data, valid strobe and out-of-range pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_d_o    <= '0;
         r_rd_vld <= 1'b0;
         r_oor    <= 1'b0;
      end else begin
         r_rd_vld <= w_accept;
         r_oor    <= w_oor_hit;
         if (w_accept) begin
            if (wr && (RD_MODE == 1)) begin
               r_d_o <= w_merged;
            end else begin
               r_d_o <= w_old;
            end
         end
      end
   end

   assign d_o    = r_d_o;
   assign rd_vld = r_rd_vld;
   assign busy   = w_busy;
   assign oor    = r_oor;

endmodule

// File: doc/mem_param_clr.md
MEM_PARAM_CLR -- requirements
Module: mem_param_clr

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, the data word width in bits (>=1).
REQ-002 The block SHALL take parameter DEPTH, default 1024, the number of words (>=2, power of two not required).
REQ-003 The block SHALL take parameter RD_MODE, default 0, where 0 = read-first and 1 = write-first on a write access.
REQ-004 The block SHALL take parameter CLR_VAL, default 0, a WIDTH-bit value written to every word by the clear engine.
REQ-005 The block SHALL derive AW = max(1, ceil(log2(DEPTH))) as the address width.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have port en, input, 1 bit: access request for this cycle.
REQ-009 The block SHALL have port wr, input, 1 bit: 1 = write access, 0 = read access (valid with en).
REQ-010 The block SHALL have port addr, input, AW bits: word address.
REQ-011 The block SHALL have port d_i, input, WIDTH bits: write data.
REQ-012 The block SHALL have port wmask, input, WIDTH bits: per-bit write enable (1 = bit updated).
REQ-013 The block SHALL have port clr_req, input, 1 bit: request a full-array clear.
REQ-014 The block SHALL have port d_o, output, WIDTH bits: registered read data.
REQ-015 The block SHALL have port rd_vld, output, 1 bit: d_o updated by an access accepted on the previous edge.
REQ-016 The block SHALL have port busy, output, 1 bit: clear engine active; accesses are refused.
REQ-017 The block SHALL have port oor, output, 1 bit: one-cycle pulse flagging a refused out-of-range access.

Function
REQ-018 The clear engine SHALL have two states, IDLE and CLEAR, plus an AW-bit sweep counter cnt, with busy = (state == CLEAR).
REQ-019 On each edge in CLEAR with rst low, the block SHALL write mem[cnt] <= CLR_VAL, then increment cnt; the edge that writes DEPTH-1 SHALL move the state to IDLE.
REQ-020 An edge in IDLE with clr_req=1 SHALL move the state to CLEAR with cnt=0; clr_req SHALL be ignored in CLEAR.
REQ-021 An access SHALL be accepted when en=1, busy=0, rst=0 and addr < DEPTH; all other en=1 cycles SHALL be refused with no array change.
REQ-022 A refused access with busy=0 and addr >= DEPTH SHALL set oor=1 for exactly the next cycle; busy-refused accesses SHALL NOT pulse oor.
REQ-023 An accepted write SHALL update mem[addr] <= (mem[addr] & ~wmask) | (d_i & wmask) on that edge; wmask=0 SHALL leave the word unchanged.
REQ-024 An accepted access SHALL load d_o on the same edge, giving 1-cycle latency, and SHALL set rd_vld=1 for the following cycle.
REQ-025 For a read, d_o SHALL be mem[addr]; for a write, d_o SHALL be the pre-write word when RD_MODE=0 and the merged new word when RD_MODE=1.
REQ-026 Without an accepted access, d_o SHALL hold its value and rd_vld SHALL be 0.
REQ-027 If an IDLE cycle has both clr_req=1 and an acceptable access, the access SHALL complete normally on that edge and the clear SHALL begin on the next edge.
REQ-028 Back-to-back accepted accesses SHALL be supported every cycle with no bubbles.

Reset
REQ-029 An edge with rst=1 SHALL set state=CLEAR, cnt=0, d_o=0, rd_vld=0 and oor=0, and SHALL perform no array write.
REQ-030 rst SHALL dominate en and clr_req; a reset during CLEAR SHALL restart the sweep from address 0.
REQ-031 After rst falls, busy SHALL remain 1 for exactly DEPTH edges; array contents before the sweep completes are undefined.

Verification
REQ-032 Reset, then release with DEPTH=1024 -> busy=1 for 1024 cycles then 0; reads of addresses 0, 511 and 1023 -> d_o=CLR_VAL with rd_vld=1 one cycle later.
REQ-033 Write 0xA5 with wmask=0xFF to addr 7, then write 0x0F with wmask=0x0F to addr 7, then read addr 7 -> d_o=0xAF; a write with wmask=0x00 leaves 0xAF.
REQ-034 Write 0x3C to addr 5 over old value 0x11 -> d_o=0x11 (RD_MODE=0) or 0x3C (RD_MODE=1) on the next cycle.
REQ-035 DEPTH=10, access to addr 12 -> oor=1 for one cycle, rd_vld=0, d_o unchanged, and no write to any address.
REQ-036 clr_req together with a write of 0x77 to addr 3 -> write completes and busy rises next cycle; rst mid-sweep at cnt=400 -> the sweep restarts at 0; read after completion -> CLR_VAL; en during busy -> rd_vld=0.
